// File: rtl/boss_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : boss_stage_ctrl
// Description : Boss-stage sequencer. Frame-counted intro with the boss held
//               frozen, the fight itself, a frame-counted outro, and a
//               one-cycle win/loss result pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module boss_stage_ctrl #(
  parameter int INTRO_FRAMES    = 120,
  parameter int OUTRO_FRAMES    = 90,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       stage_start,
  input  logic       abort,
  input  logic       pause,
  input  logic       boss_dead,
  input  logic       player_dead,
  output logic       boss_enable,
  output logic       boss_resetN,
  output logic       intro_active,
  output logic       stage_won,
  output logic       stage_lost,
  output logic       result_won,
  output logic [2:0] stage_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INTRO      = 3'd1,
    S_FIGHT      = 3'd2,
    S_OUTRO_WIN  = 3'd3,
    S_OUTRO_LOSE = 3'd4,
    S_DONE       = 3'd5
  } state_e;

  localparam logic [FRAME_CNT_WIDTH-1:0] C_INTRO_LAST = FRAME_CNT_WIDTH'(INTRO_FRAMES - 1);
  localparam logic [FRAME_CNT_WIDTH-1:0] C_OUTRO_LAST = FRAME_CNT_WIDTH'(OUTRO_FRAMES - 1);
  localparam logic [FRAME_CNT_WIDTH-1:0] C_CNT_ZERO   = '0;
  localparam logic [FRAME_CNT_WIDTH-1:0] C_CNT_ONE    = FRAME_CNT_WIDTH'(1);

  state_e                     st_q, st_d;
  logic [FRAME_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       won_q, won_d;
  logic                       lost_q, lost_d;
  logic                       result_q, result_d;
  logic                       frame_tick;

  assign frame_tick = startOfFrame & ~pause;

  always_ff @(posedge clk) begin
    if (resetN) begin
      st_q     <= S_IDLE;
      cnt_q    <= C_CNT_ZERO;
      won_q    <= 1'b0;
      lost_q   <= 1'b0;
      result_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      won_q    <= won_d;
      lost_q   <= lost_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    won_d    = 1'b0;
    lost_d   = 1'b0;
    result_d = result_q;
    case (st_q)
      S_IDLE, S_DONE: begin
        if (stage_start) begin
          st_d  = S_INTRO;
          cnt_d = C_CNT_ZERO;
        end
      end
      S_INTRO: begin
        if (frame_tick) begin
          if (cnt_q == C_INTRO_LAST) begin
            st_d  = S_FIGHT;
            cnt_d = C_CNT_ZERO;
          end else begin
            cnt_d = cnt_q + C_CNT_ONE;
          end
        end
      end
      S_FIGHT: begin
        // Simultaneous deaths resolve as a loss.
        if (player_dead) begin
          st_d  = S_OUTRO_LOSE;
          cnt_d = C_CNT_ZERO;
        end else if (boss_dead) begin
          st_d  = S_OUTRO_WIN;
          cnt_d = C_CNT_ZERO;
        end
      end
      S_OUTRO_WIN, S_OUTRO_LOSE: begin
        if (frame_tick) begin
          if (cnt_q == C_OUTRO_LAST) begin
            st_d     = S_DONE;
            cnt_d    = C_CNT_ZERO;
            won_d    = (st_q == S_OUTRO_WIN);
            lost_d   = (st_q == S_OUTRO_LOSE);
            result_d = (st_q == S_OUTRO_WIN);
          end else begin
            cnt_d = cnt_q + C_CNT_ONE;
          end
        end
      end
      default: begin
        st_d  = S_IDLE;
        cnt_d = C_CNT_ZERO;
      end
    endcase
    if (abort) begin
      st_d   = S_IDLE;
      cnt_d  = C_CNT_ZERO;
      won_d  = 1'b0;
      lost_d = 1'b0;
    end
  end

  assign boss_enable  = (st_q == S_FIGHT) & ~pause;
  assign boss_resetN  = ~((st_q == S_IDLE) | (st_q == S_DONE));
  assign intro_active = (st_q == S_INTRO);
  assign stage_won    = won_q;
  assign stage_lost   = lost_q;
  assign result_won   = result_q;
  assign stage_state  = st_q;

endmodule
`default_nettype wire
